// File: rtl/btn_press_decoder.sv
// Classifies presses of a debounced button into short, double and long
// (with auto-repeat) events. All outputs are registered one-cycle pulses plus a held level.
module btn_press_decoder #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LONG_CYCLES   = 1000000,
  parameter int REPEAT_CYCLES = 200000,
  parameter int DBL_CYCLES    = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int MAX_LR     = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int MAX_CYCLES = (MAX_LR > DBL_CYCLES) ? MAX_LR : DBL_CYCLES;
  localparam int CTR_W      = $clog2(MAX_CYCLES);

  localparam logic [CTR_W-1:0] LONG_LAST = CTR_W'(LONG_CYCLES - 1);
  localparam logic [CTR_W-1:0] REP_LAST  = CTR_W'(REPEAT_CYCLES - 1);
  localparam logic [CTR_W-1:0] DBL_LAST  = CTR_W'(DBL_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_WAIT2,
    ST_PRESS2,
    ST_LONG
  } state_t;

  state_t           state_reg, state_next;
  logic [CTR_W-1:0] ctr_reg, ctr_next;
  logic             btn_reg;
  logic             btn_level;

  logic press_reg, short_reg, double_reg, long_reg, repeat_reg, held_reg;
  logic press_next, short_next, double_next, long_next, repeat_next, held_next;

  assign btn_level = ACTIVE_LOW ? ~i_btn : i_btn;

  // State register: FSM state, shared counter, sampled button and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      ctr_reg    <= '0;
      btn_reg    <= 1'b0;
      press_reg  <= 1'b0;
      short_reg  <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;
      held_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctr_reg    <= ctr_next;
      btn_reg    <= btn_level;
      press_reg  <= press_next;
      short_reg  <= short_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      repeat_reg <= repeat_next;
      held_reg   <= held_next;
    end
  end

  // Next-state logic; release/press checks take priority over counter thresholds
  always_comb begin
    state_next = state_reg;
    ctr_next   = ctr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (btn_reg) state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!btn_reg)                 state_next = ST_WAIT2;
        else if (ctr_reg == LONG_LAST) state_next = ST_LONG;
        else                          ctr_next   = ctr_reg + CTR_ONE;
      end
      ST_WAIT2: begin
        if (btn_reg)                  state_next = ST_PRESS2;
        else if (ctr_reg == DBL_LAST) state_next = ST_IDLE;
        else                          ctr_next   = ctr_reg + CTR_ONE;
      end
      ST_PRESS2: begin
        if (!btn_reg)                 state_next = ST_IDLE;
        else if (ctr_reg == LONG_LAST) state_next = ST_LONG;
        else                          ctr_next   = ctr_reg + CTR_ONE;
      end
      ST_LONG: begin
        if (!btn_reg)                 state_next = ST_IDLE;
        else if (ctr_reg == REP_LAST) ctr_next   = '0;
        else                          ctr_next   = ctr_reg + CTR_ONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next != state_reg) ctr_next = '0;
  end

  // Output logic: pulse conditions mirror the transitions above
  always_comb begin
    press_next  = btn_reg && ((state_reg == ST_IDLE) || (state_reg == ST_WAIT2));
    short_next  = (state_reg == ST_WAIT2) && !btn_reg && (ctr_reg == DBL_LAST);
    double_next = (state_reg == ST_PRESS2) && !btn_reg;
    long_next   = ((state_reg == ST_PRESS1) || (state_reg == ST_PRESS2)) && btn_reg
                  && (ctr_reg == LONG_LAST);
    repeat_next = (state_reg == ST_LONG) && btn_reg && (ctr_reg == REP_LAST);
    held_next   = (state_next == ST_PRESS1) || (state_next == ST_PRESS2)
                  || (state_next == ST_LONG);
  end

  assign o_press  = press_reg;
  assign o_short  = short_reg;
  assign o_double = double_reg;
  assign o_long   = long_reg;
  assign o_repeat = repeat_reg;
  assign o_held   = held_reg;

endmodule
